// File: rtl/fetch_targ_pred.sv
// Fetch-stage next-PC predictor: JAL/branch target adders, circular return-address stack,
// and static BTFN or (with `TARG_BHT_EN defined) 2-bit BHT branch direction prediction.
module fetch_targ_pred #(
    parameter int XLEN        = 32,
    parameter int RAS_DEPTH   = 4,
    parameter int BHT_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            f_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     f_ir,
    input  logic [XLEN-1:0] f_pc,
    input  logic            ex_upd,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic [XLEN-1:0] next_pc,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int BW = $clog2(BHT_ENTRIES);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    logic            is_jal_s, is_br_s, is_jalr_s;
    logic            rd_link_s, rs1_link_s;
    logic            call_s, ret_s, poppush_s, upd_s, br_dir_s;
    logic [XLEN-1:0] j_imm_s, b_imm_s, pc4_s, ras_top_s;

    logic [XLEN-1:0] ras_r [RAS_DEPTH];
    logic [PW-1:0]   ptr_r;
    logic [CW-1:0]   count_r;

    // Opcode decode
    always_comb begin
        is_jal_s  = 1'b0;
        is_br_s   = 1'b0;
        is_jalr_s = 1'b0;
        case (f_ir[6:0])
            OP_JAL:    is_jal_s  = 1'b1;
            OP_BRANCH: is_br_s   = 1'b1;
            OP_JALR:   is_jalr_s = 1'b1;
            default:   is_jal_s  = 1'b0;
        endcase
    end

    assign rd_link_s  = is_link(f_ir[11:7]);
    assign rs1_link_s = is_link(f_ir[19:15]);
    assign call_s     = (is_jal_s | is_jalr_s) & rd_link_s;
    assign ret_s      = is_jalr_s & rs1_link_s & ~rd_link_s;
    // x1/x5 coroutine swap: replace the top instead of growing the stack
    assign poppush_s  = is_jalr_s & rd_link_s & rs1_link_s & (f_ir[11:7] != f_ir[19:15]);
    assign upd_s      = f_valid & ~stall & ~flush & ~rst;

    assign j_imm_s = {{(XLEN-20){f_ir[31]}}, f_ir[19:12], f_ir[20], f_ir[30:21], 1'b0};
    assign b_imm_s = {{(XLEN-12){f_ir[31]}}, f_ir[7], f_ir[30:25], f_ir[11:8], 1'b0};
    assign pc4_s   = f_pc + XLEN'(4);

    assign ras_top_s = ras_r[ptr_r - PW'(1)];
    assign ras_empty = (count_r == CW'(0));
    assign ras_full  = (count_r == CW'(RAS_DEPTH));

`ifdef TARG_BHT_EN
    logic [1:0]    bht_r [BHT_ENTRIES];
    logic [BW-1:0] f_idx_s, ex_idx_s;
    logic          unused_ex_pc_s;

    assign f_idx_s        = f_pc[BW+1:2];
    assign ex_idx_s       = ex_pc[BW+1:2];
    assign br_dir_s       = bht_r[f_idx_s][1];
    assign unused_ex_pc_s = ^{ex_pc[XLEN-1:BW+2], ex_pc[1:0]};

    // BHT training from EX resolution; saturating 2-bit counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_r[i] <= 2'b01;
        end else if (ex_upd) begin
            if (ex_taken && (bht_r[ex_idx_s] != 2'b11))
                bht_r[ex_idx_s] <= bht_r[ex_idx_s] + 2'b01;
            else if (!ex_taken && (bht_r[ex_idx_s] != 2'b00))
                bht_r[ex_idx_s] <= bht_r[ex_idx_s] - 2'b01;
        end
    end
`else
    logic unused_ex_s;

    assign br_dir_s    = f_ir[31];
    assign unused_ex_s = ^{ex_upd, ex_taken, ex_pc};
`endif

    // Prediction and target selection
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = XLEN'(0);
        if (is_jal_s) begin
            pred_taken  = 1'b1;
            pred_target = f_pc + j_imm_s;
        end else if (is_br_s && br_dir_s) begin
            pred_taken  = 1'b1;
            pred_target = f_pc + b_imm_s;
        end else if (ret_s && !ras_empty) begin
            pred_taken  = 1'b1;
            pred_target = {ras_top_s[XLEN-1:1], 1'b0};
        end else begin
            pred_taken  = 1'b0;
            pred_target = XLEN'(0);
        end
    end

    assign next_pc = pred_taken ? pred_target : pc4_s;

    // Return-address stack; a push when full overwrites the oldest entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r   <= PW'(0);
            count_r <= CW'(0);
            for (int i = 0; i < RAS_DEPTH; i++) ras_r[i] <= XLEN'(0);
        end else if (upd_s) begin
            if (poppush_s) begin
                ras_r[ptr_r - PW'(1)] <= pc4_s;
                if (count_r == CW'(0)) count_r <= CW'(1);
            end else if (call_s) begin
                ras_r[ptr_r] <= pc4_s;
                ptr_r        <= ptr_r + PW'(1);
                if (!ras_full) count_r <= count_r + CW'(1);
            end else if (ret_s && !ras_empty) begin
                ptr_r   <= ptr_r - PW'(1);
                count_r <= count_r - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_targ_pred.sv
// Directed self-checking bench for fetch_targ_pred (default RAS_DEPTH=4); the BHT
// scenario is built when TARG_BHT_EN is defined, otherwise static BTFN is checked.
module tb_fetch_targ_pred;

    logic        clk, rst, f_valid, stall, flush, ex_upd, ex_taken;
    logic [31:0] f_ir, f_pc, ex_pc;
    logic        pred_taken, ras_empty, ras_full;
    logic [31:0] pred_target, next_pc;
    int          n_checks = 0;
    int          n_fail   = 0;

    fetch_targ_pred dut (
        .clk(clk), .rst(rst), .f_valid(f_valid), .stall(stall), .flush(flush),
        .f_ir(f_ir), .f_pc(f_pc), .ex_upd(ex_upd), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .pred_taken(pred_taken), .pred_target(pred_target), .next_pc(next_pc),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h000, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc);
        f_ir = ir;
        f_pc = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; f_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        ex_upd = 1'b0; ex_taken = 1'b0; ex_pc = 32'h0;
        drive(enc_jalr(5'd0, 5'd1), 32'h0000_0040);
        #1;
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
        n_checks++; if (ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", ras_full); end
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_ret_taken: got %b want 0", pred_taken); end
        n_checks++; if (next_pc !== 32'h44) begin n_fail++; $display("FAIL reset_next_pc: got %h want 00000044", next_pc); end
        tick();
        f_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_jal();
        f_valid = 1'b1;
        drive(enc_jal(5'd0, 21'h00020), 32'h0000_0100);
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL jal_taken: got %b want 1", pred_taken); end
        n_checks++; if (next_pc !== 32'h120) begin n_fail++; $display("FAIL jal_next_pc: got %h want 00000120", next_pc); end
        n_checks++; if (pred_target !== 32'h120) begin n_fail++; $display("FAIL jal_target: got %h want 00000120", pred_target); end
        tick();
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL jal_ras_unchanged: got %b want 1", ras_empty); end
        f_valid = 1'b0;
    endtask

    task automatic test_branch_static();
        drive(enc_beq(13'h1FF8), 32'h0000_0200);
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL beq_back_taken: got %b want 1", pred_taken); end
        n_checks++; if (next_pc !== 32'h1F8) begin n_fail++; $display("FAIL beq_back_next_pc: got %h want 000001f8", next_pc); end
        drive(enc_beq(13'h0008), 32'h0000_0200);
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL beq_fwd_taken: got %b want 0", pred_taken); end
        n_checks++; if (next_pc !== 32'h204) begin n_fail++; $display("FAIL beq_fwd_next_pc: got %h want 00000204", next_pc); end
        n_checks++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL beq_fwd_target: got %h want 00000000", pred_target); end
    endtask

    task automatic test_call_return();
        f_valid = 1'b1;
        drive(enc_jal(5'd1, 21'h00040), 32'h0000_0300);
        n_checks++; if (next_pc !== 32'h340) begin n_fail++; $display("FAIL call_next_pc: got %h want 00000340", next_pc); end
        tick();
        n_checks++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL call_pushed: got %b want 0", ras_empty); end
        drive(enc_jalr(5'd0, 5'd1), 32'h0000_0340);
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL ret_taken: got %b want 1", pred_taken); end
        n_checks++; if (next_pc !== 32'h304) begin n_fail++; $display("FAIL ret_next_pc: got %h want 00000304", next_pc); end
        tick();
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret_popped: got %b want 1", ras_empty); end
        f_valid = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] exp_ret [4];
        exp_ret = '{32'h54, 32'h44, 32'h34, 32'h24};
        f_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(enc_jal(5'd1, 21'h00100), 32'h10 * (i + 1));
            tick();
            if (i == 2) begin
                n_checks++; if (ras_full !== 1'b0) begin n_fail++; $display("FAIL ovf_not_full_3: got %b want 0", ras_full); end
            end
        end
        n_checks++; if (ras_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b want 1", ras_full); end
        for (int i = 0; i < 4; i++) begin
            drive(enc_jalr(5'd0, 5'd1), 32'h0000_0800);
            n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL ovf_ret%0d_taken: got %b want 1", i, pred_taken); end
            n_checks++; if (next_pc !== exp_ret[i]) begin n_fail++; $display("FAIL ovf_ret%0d_next_pc: got %h want %h", i, next_pc, exp_ret[i]); end
            tick();
        end
        drive(enc_jalr(5'd0, 5'd1), 32'h0000_0800);
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL ovf_ret5_taken: got %b want 0", pred_taken); end
        n_checks++; if (next_pc !== 32'h804) begin n_fail++; $display("FAIL ovf_ret5_next_pc: got %h want 00000804", next_pc); end
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got %b want 1", ras_empty); end
        tick();
        f_valid = 1'b0;
    endtask

    task automatic test_stall_flush_reset();
        f_valid = 1'b1;
        stall = 1'b1;
        drive(enc_jal(5'd1, 21'h00100), 32'h0000_0600);
        tick();
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL stall_no_push: got %b want 1", ras_empty); end
        stall = 1'b0;
        flush = 1'b1;
        tick();
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL flush_no_push: got %b want 1", ras_empty); end
        flush = 1'b0;
        tick();
        tick();
        drive(enc_jalr(5'd0, 5'd1), 32'h0000_0700);
        n_checks++; if (next_pc !== 32'h604) begin n_fail++; $display("FAIL pre_rst_ret: got %h want 00000604", next_pc); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL async_rst_empty: got %b want 1", ras_empty); end
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL async_rst_ret_taken: got %b want 0", pred_taken); end
        n_checks++; if (next_pc !== 32'h704) begin n_fail++; $display("FAIL async_rst_next_pc: got %h want 00000704", next_pc); end
        f_valid = 1'b0;
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_poppush();
        f_valid = 1'b1;
        drive(enc_jalr(5'd1, 5'd5), 32'h0000_0A00);
        n_checks++; if (next_pc !== 32'hA04) begin n_fail++; $display("FAIL pp_empty_next_pc: got %h want 00000a04", next_pc); end
        tick();
        n_checks++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL pp_count_one: got %b want 0", ras_empty); end
        drive(enc_jalr(5'd1, 5'd5), 32'h0000_0B00);
        tick();
        drive(enc_jalr(5'd0, 5'd1), 32'h0000_0C00);
        n_checks++; if (next_pc !== 32'hB04) begin n_fail++; $display("FAIL pp_top_replaced: got %h want 00000b04", next_pc); end
        tick();
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL pp_count_kept: got %b want 1", ras_empty); end
        drive(enc_jalr(5'd1, 5'd1), 32'h0000_0D00);
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL same_link_taken: got %b want 0", pred_taken); end
        tick();
        drive(enc_jalr(5'd0, 5'd5), 32'h0000_0E00);
        n_checks++; if (next_pc !== 32'hD04) begin n_fail++; $display("FAIL same_link_push: got %h want 00000d04", next_pc); end
        tick();
        f_valid = 1'b0;
    endtask

    task automatic test_wrap();
        drive(32'h0000_0013, 32'hFFFF_FFFC);
        n_checks++; if (next_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h want 00000000", next_pc); end
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL wrap_nop_taken: got %b want 0", pred_taken); end
        drive(enc_jal(5'd0, 21'h00020), 32'hFFFF_FFF0);
        n_checks++; if (next_pc !== 32'h10) begin n_fail++; $display("FAIL wrap_jal: got %h want 00000010", next_pc); end
    endtask

`ifdef TARG_BHT_EN
    task automatic test_bht();
        drive(enc_beq(13'h0010), 32'h0000_0040);
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL bht_init: got %b want 0", pred_taken); end
        ex_pc = 32'h40; ex_taken = 1'b1; ex_upd = 1'b1;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL bht_no_bypass: got %b want 0", pred_taken); end
        tick(); tick();
        ex_upd = 1'b0;
        #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL bht_trained_taken: got %b want 1", pred_taken); end
        n_checks++; if (next_pc !== 32'h50) begin n_fail++; $display("FAIL bht_taken_next_pc: got %h want 00000050", next_pc); end
        ex_taken = 1'b0; ex_upd = 1'b1;
        tick(); tick();
        ex_upd = 1'b0;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL bht_trained_nt: got %b want 0", pred_taken); end
        n_checks++; if (next_pc !== 32'h44) begin n_fail++; $display("FAIL bht_nt_next_pc: got %h want 00000044", next_pc); end
        ex_upd = 1'b1;
        tick(); tick();
        ex_upd = 1'b0;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL bht_sat_low: got %b want 0", pred_taken); end
        ex_taken = 1'b1; ex_upd = 1'b1;
        tick();
        ex_upd = 1'b0;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL bht_from_zero: got %b want 0", pred_taken); end
    endtask
`else
    task automatic test_bht();
        drive(enc_beq(13'h0010), 32'h0000_0040);
        ex_pc = 32'h40; ex_taken = 1'b1; ex_upd = 1'b1;
        tick(); tick(); tick();
        ex_upd = 1'b0;
        #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL static_ex_ignored: got %b want 0", pred_taken); end
        n_checks++; if (next_pc !== 32'h44) begin n_fail++; $display("FAIL static_ex_next_pc: got %h want 00000044", next_pc); end
    endtask
`endif

    initial begin
        test_reset();
        test_jal();
        test_branch_static();
        test_call_return();
        test_overflow();
        test_stall_flush_reset();
        test_poppush();
        test_wrap();
        test_bht();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
